// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU among NREQ requesters,
// with a single registered response slot. Optional perf counters: ALU_ARBITER_PERF_EN.
module alu_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [4*NREQ-1:0]        req_op,
    input  logic [16*NREQ-1:0]       req_rs,
    input  logic [16*NREQ-1:0]       req_rt,
    input  logic [4*NREQ-1:0]        req_imm4,
    output logic [3:0]               alu_op,
    output logic [15:0]              alu_rs,
    output logic [15:0]              alu_rt,
    output logic [3:0]               alu_imm4,
    input  logic [15:0]              alu_rd,
    input  logic                     alu_zero,
    input  logic                     alu_neg,
    input  logic                     alu_ovf,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [15:0]              rsp_rd,
    output logic [2:0]               rsp_flags
`ifdef ALU_ARBITER_PERF_EN
    ,
    output logic [15:0]              perf_busy,
    output logic [15:0]              perf_conflict
`endif
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0] last;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] sel;
    logic           found;
    logic           can_issue;

    assign can_issue = !rsp_valid || rsp_ready;

    // Search starts just past the last winner; req_ready is forced low during reset.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sel       = '0;
        if (rst_n && can_issue) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                sel = IDW'((32'(last) + k) % NREQ);
                if (!found && req_valid[sel]) begin
                    found     = 1'b1;
                    grant_idx = sel;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        alu_op    = '0;
        alu_rs    = '0;
        alu_rt    = '0;
        alu_imm4  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (found && grant_idx == IDW'(i)) begin
                req_ready[i] = 1'b1;
                alu_op       = req_op[4*i +: 4];
                alu_rs       = req_rs[16*i +: 16];
                alu_rt       = req_rt[16*i +: 16];
                alu_imm4     = req_imm4[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rd    <= '0;
            rsp_flags <= '0;
            last      <= IDW'(NREQ - 1);
        end else if (found) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant_idx;
            rsp_rd    <= alu_rd;
            rsp_flags <= {alu_ovf, alu_neg, alu_zero};
            last      <= grant_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARBITER_PERF_EN
    int unsigned n_valid;
    logic        conflict;

    always_comb begin
        n_valid = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            n_valid = n_valid + 32'(req_valid[i]);
        end
        conflict = (n_valid >= 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy     <= '0;
            perf_conflict <= '0;
        end else begin
            if (found && perf_busy != '1)
                perf_busy <= perf_busy + 16'd1;
            if (conflict && perf_conflict != '1)
                perf_conflict <= perf_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NREQ=2) with a small behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic [7:0]  req_imm4;
    logic [3:0]  alu_op;
    logic [15:0] alu_rs;
    logic [15:0] alu_rt;
    logic [3:0]  alu_imm4;
    logic [15:0] alu_rd;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_ovf;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_rd;
    logic [2:0]  rsp_flags;
`ifdef ALU_ARBITER_PERF_EN
    logic [15:0] perf_busy;
    logic [15:0] perf_conflict;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_imm4(req_imm4),
        .alu_op(alu_op), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_imm4(alu_imm4),
        .alu_rd(alu_rd), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rd(rsp_rd), .rsp_flags(rsp_flags)
`ifdef ALU_ARBITER_PERF_EN
        , .perf_busy(perf_busy), .perf_conflict(perf_conflict)
`endif
    );

    // Behavioural ALU: 0000 add, 0001 sub, 1100 rs+imm4, otherwise rs&rt
    always_comb begin
        alu_ovf = 1'b0;
        case (alu_op)
            4'b0000: begin
                alu_rd  = alu_rs + alu_rt;
                alu_ovf = (alu_rs[15] == alu_rt[15]) && (alu_rd[15] != alu_rs[15]);
            end
            4'b0001: begin
                alu_rd  = alu_rs - alu_rt;
                alu_ovf = (alu_rs[15] != alu_rt[15]) && (alu_rd[15] != alu_rs[15]);
            end
            4'b1100: alu_rd = alu_rs + {12'd0, alu_imm4};
            default: alu_rd = alu_rs & alu_rt;
        endcase
        alu_zero = (alu_rd == 16'd0);
        alu_neg  = alu_rd[15];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] rs,
                           input logic [15:0] rt, input logic [3:0] imm);
        req_op[4*i +: 4]    = op;
        req_rs[16*i +: 16]  = rs;
        req_rt[16*i +: 16]  = rt;
        req_imm4[4*i +: 4]  = imm;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_valid = 2'($urandom);
            req_op    = 8'($urandom);
            req_rs    = $urandom;
            req_rt    = $urandom;
            req_imm4  = 8'($urandom);
            rsp_ready = 1'($urandom);
            step();
            vectors++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("FAIL reset_ready: got %b want 00", req_ready);
            end
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rd !== 16'h0 || rsp_flags !== 3'b000 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b rd=%h f=%b id=%0d want 0/0000/000/0",
                     rsp_valid, rsp_rd, rsp_flags, rsp_id);
        end
`ifdef ALU_ARBITER_PERF_EN
        vectors++;
        if (perf_busy !== 16'h0 || perf_conflict !== 16'h0) begin
            errors++;
            $display("FAIL reset_perf: got %h/%h want 0/0", perf_busy, perf_conflict);
        end
`endif
        set_req(0, 4'b0000, 16'd1, 16'd2, 4'd0);
        set_req(1, 4'b0001, 16'd5, 16'd5, 4'd0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rd !== 16'h0003) begin
            errors++;
            $display("FAIL reset_first_rsp: got v=%b id=%0d rd=%h want 1/0/0003",
                     rsp_valid, rsp_id, rsp_rd);
        end
        step();
    endtask

    task automatic test_single();
        set_req(0, 4'b0000, 16'h7FFF, 16'h0001, 4'd0);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rd !== 16'h8000 || rsp_flags !== 3'b110) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%0d rd=%h f=%b want 1/0/8000/110",
                     rsp_valid, rsp_id, rsp_rd, rsp_flags);
        end
        step();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_ready;
        do_reset();
        set_req(0, 4'b0000, 16'd1, 16'd2, 4'd0);
        set_req(1, 4'b0001, 16'd5, 16'd5, 4'd0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            vectors++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, exp_ready);
            end
            step();
            vectors++;
            if (k % 2 == 0) begin
                if (rsp_id !== 1'b0 || rsp_rd !== 16'h0003 || rsp_flags !== 3'b000) begin
                    errors++;
                    $display("FAIL fair_rsp[%0d]: got id=%0d rd=%h f=%b want 0/0003/000",
                             k, rsp_id, rsp_rd, rsp_flags);
                end
            end else begin
                if (rsp_id !== 1'b1 || rsp_rd !== 16'h0000 || rsp_flags !== 3'b001) begin
                    errors++;
                    $display("FAIL fair_rsp[%0d]: got id=%0d rd=%h f=%b want 1/0000/001",
                             k, rsp_id, rsp_rd, rsp_flags);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b1 ||
                rsp_rd !== 16'h0000 || rsp_flags !== 3'b001) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d rd=%h f=%b want 00/1/1/0000/001",
                         c, req_ready, rsp_valid, rsp_id, rsp_rd, rsp_flags);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_release_grant: got %b want 01", req_ready);
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rd !== 16'h0003) begin
            errors++;
            $display("FAIL bp_release_rsp: got v=%b id=%0d rd=%h want 1/0/0003",
                     rsp_valid, rsp_id, rsp_rd);
        end
    endtask

    task automatic test_load_addr();
        set_req(1, 4'b1100, 16'h0100, 16'h0000, 4'hF);
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b10 || alu_op !== 4'b1100 || alu_imm4 !== 4'hF) begin
            errors++;
            $display("FAIL ld_grant: got rdy=%b op=%b imm=%h want 10/1100/f",
                     req_ready, alu_op, alu_imm4);
        end
        step();
        req_valid = 2'b00;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_rd !== 16'h010F || rsp_flags !== 3'b000) begin
            errors++;
            $display("FAIL ld_rsp: got v=%b id=%0d rd=%h f=%b want 1/1/010f/000",
                     rsp_valid, rsp_id, rsp_rd, rsp_flags);
        end
        #1;
        vectors++;
        if (alu_op !== 4'b0000 || alu_rs !== 16'h0 || alu_rt !== 16'h0 || alu_imm4 !== 4'h0) begin
            errors++;
            $display("FAIL idle_alu: got op=%b rs=%h rt=%h imm=%h want zeros",
                     alu_op, alu_rs, alu_rt, alu_imm4);
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b1 || rsp_rd !== 16'h010F) begin
            errors++;
            $display("FAIL drain_hold: got v=%b id=%0d rd=%h want 0/1/010f",
                     rsp_valid, rsp_id, rsp_rd);
        end
    endtask

    task automatic test_lone();
        set_req(0, 4'b0000, 16'd1, 16'd2, 4'd0);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (req_ready !== 2'b01) begin
                errors++;
                $display("FAIL lone_grant[%0d]: got %b want 01", c, req_ready);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL midrst_async: got v=%b rdy=%b want 0/00", rsp_valid, req_ready);
        end
`ifdef ALU_ARBITER_PERF_EN
        vectors++;
        if (perf_busy !== 16'h0 || perf_conflict !== 16'h0) begin
            errors++;
            $display("FAIL midrst_perf: got %h/%h want 0/0", perf_busy, perf_conflict);
        end
`endif
        step();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midrst_grant: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rd !== 16'h0003) begin
            errors++;
            $display("FAIL midrst_rsp: got v=%b id=%0d rd=%h want 1/0/0003",
                     rsp_valid, rsp_id, rsp_rd);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_rs    = '0;
        req_rt    = '0;
        req_imm4  = '0;
        rsp_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_load_addr();
        test_lone();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter that shares one combinational 16-bit ALU between NREQ requesters, such as the execute stage and the address/branch helper.
- Each requester uses a valid/ready handshake to submit an operation: aluop, rs, rt, imm4.
- The arbiter muxes the winning operands onto the ALU ports and registers the ALU result and flags into a single-entry response slot.
- The response slot carries a requester ID and has its own valid/ready handshake.

Parameters:
NREQ, 2, number of requesters; legal range 2..8.
IDW, localparam = $clog2(NREQ), width of the requester ID.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  per-requester accept; one-hot or zero.
req_op  in  4*NREQ  aluop for requester i at [4i+3:4i].
req_rs  in  16*NREQ  operand 1 for requester i at [16i+15:16i].
req_rt  in  16*NREQ  operand 2.
req_imm4  in  4*NREQ  4-bit unsigned immediate.
alu_op  out  4  to ALU aluop.
alu_rs  out  16  to ALU src1.
alu_rt  out  16  to ALU src2.
alu_imm4  out  4  to ALU immediate.
alu_rd  in  16  ALU result.
alu_zero  in  1  ALU zero flag.
alu_neg  in  1  ALU negative flag.
alu_ovf  in  1  ALU overflow flag.
rsp_valid  out  1  response slot full.
rsp_ready  in  1  consumer accepts the response.
rsp_id  out  IDW  index of the requester that owns the response.
rsp_rd  out  16  registered result.
rsp_flags  out  3  registered {ovf, neg, zero}.

Behaviour:
- Reset (asynchronous assert, synchronous deassert usage):
  - rsp_valid=0, rsp_id=0, rsp_rd=0, rsp_flags=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - req_ready=0 while rst_n is low.
- Slot availability:
  - can_issue = !rsp_valid || rsp_ready.
  - The slot is reusable in the same cycle it drains, giving 1 op/cycle throughput.
- Grant (combinational):
  - If can_issue, grant the first i with req_valid[i]=1, searching last+1, last+2, … modulo NREQ.
  - req_ready[i]=1 only for the granted i.
  - No grant → req_ready all 0.
- ALU drive:
  - Granted requester's op/rs/rt/imm4 are driven onto alu_*.
  - With no grant, alu_op=4'b0000, alu_rs=0, alu_rt=0, alu_imm4=0.
  - The ALU is purely combinational, so alu_rd and flags are valid in the same cycle.
- Accept (valid & ready for some i), at the rising edge:
  - rsp_rd←alu_rd, rsp_flags←{alu_ovf, alu_neg, alu_zero}, rsp_id←i, rsp_valid←1, last←i.
  - Latency: accepted in cycle N → rsp_valid=1 in cycle N+1.
- Drain without accept (rsp_valid & rsp_ready, no grant):
  - rsp_valid←0.
  - rsp_rd/flags/id hold their previous values.
- Backpressure (rsp_valid & !rsp_ready):
  - rsp_* held stable.
  - No grant, and last is unchanged.
- Pointer rules:
  - last updates only on acceptance.
  - A requester that deasserts valid before it is granted loses nothing.
  - A lone requester is granted every cycle.
- Requester obligation: op and operands stay stable while valid & !ready. The arbiter does not check this.
- Result width: rsp_rd is 16 bits exactly as returned by the ALU, with no extension. Branch ops (1001–1011) are issued and returned like any other op.
- Reset mid-operation: any in-flight response is discarded (rsp_valid←0) and the pointer returns to NREQ-1. No response is produced for a request accepted in the cycle rst_n falls.

Optional Feature:
- Macro ALU_ARBITER_PERF_EN.
- When defined, two extra outputs are added:
  - perf_busy (16): counts cycles with any accept.
  - perf_conflict (16): counts cycles where ≥2 req_valid bits are set, including stalled cycles.
- Both counters saturate at 16'hFFFF and reset to 0 on rst_n low.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with random inputs → rsp_valid=0, rsp_rd=0, rsp_flags=0, req_ready=0. Release → first contended grant goes to requester 0.
- Single op: req0 add 0x7FFF+0x0001, rsp_ready=1 → req_ready=01 in cycle N. Cycle N+1: rsp_valid=1, rsp_id=0, rsp_rd=0x8000, rsp_flags=3'b110.
- Fairness: NREQ=2, both valid every cycle, rsp_ready=1 → grants alternate 0,1,0,1 for 8 cycles; rsp_id follows one cycle later. Req1 sub 5-5 returns rsp_rd=0, flags=3'b001.
- Backpressure: slot full with rsp_ready=0 for 3 cycles → req_ready=00 and rsp_* stable. Raise rsp_ready → drain and next accept in the same cycle; the new response appears the following cycle.
- Load address: req1 op 1100, rs=0x0100, imm4=0xF → rsp_rd=0x010F, flags=000, rsp_id=1.
- Reset mid-stream: pulse rst_n low while rsp_valid=1 and both requests valid → rsp_valid=0 immediately (asynchronous). After release, requester 0 is granted first. With ALU_ARBITER_PERF_EN, counters read 0.
